// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write-port controller.
package regfile_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned NUM_REGS   = 16;
    localparam logic [3:0]  REG_PC     = 4'd15;

    typedef enum logic {
        GNT_A,
        GNT_B
    } grant_t;

endpackage

// File: rtl/regfile_write_ctrl_if.sv
// Valid/ready write-source bundle: ALU writeback (A) and memory-load writeback (B).
interface regfile_write_ctrl_if #(
    parameter int unsigned DATA_WIDTH = regfile_pkg::DATA_WIDTH
);

    logic                  A_VALID;
    logic                  A_READY;
    logic [3:0]            A_RD;
    logic [DATA_WIDTH-1:0] A_DATA;
    logic                  B_VALID;
    logic                  B_READY;
    logic [3:0]            B_RD;
    logic [DATA_WIDTH-1:0] B_DATA;

    modport master (
        output A_VALID, A_RD, A_DATA, B_VALID, B_RD, B_DATA,
        input  A_READY, B_READY
    );

    modport slave (
        input  A_VALID, A_RD, A_DATA, B_VALID, B_RD, B_DATA,
        output A_READY, B_READY
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the loser of the last transfer wins the next tie.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       hold,
    input  logic       accept,
    output logic [1:0] gnt
);
    import regfile_pkg::*;

    grant_t last_q;

    always_comb begin
        gnt = '0;
        if (rst_n && !hold) begin
            if (req == 2'b11) begin
                gnt = (last_q == GNT_B) ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= GNT_B;
        end else if (accept) begin
            last_q <= gnt[0] ? GNT_A : GNT_B;
        end
    end

endmodule

// File: rtl/regfile_write_ctrl.sv
// Arbitrates the single register-file write port between two sources, redirects
// PC writes to a PC-load strobe, and tracks per-register outstanding reservations.
module regfile_write_ctrl #(
    parameter int unsigned DATA_WIDTH = regfile_pkg::DATA_WIDTH,
    parameter int unsigned NUM_REGS   = regfile_pkg::NUM_REGS,
    parameter logic [3:0]  PC_INDEX   = regfile_pkg::REG_PC,
    parameter int unsigned CNT_WIDTH  = 2
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  HOLD,
    regfile_write_ctrl_if.slave   src,
    input  logic                  RSV_VALID,
    input  logic [3:0]            RSV_RD,
    output logic [DATA_WIDTH-1:0] PW,
    output logic [3:0]            RW,
    output logic                  LE,
    output logic                  PC_LOAD,
    output logic [DATA_WIDTH-1:0] PC_VALUE,
    output logic [NUM_REGS-1:0]   BUSY,
    output logic                  SB_OVF,
    output logic                  SB_UNF
);
    import regfile_pkg::*;

    logic [1:0]            gnt;
    logic                  xfer;
    logic                  is_pc;
    logic [3:0]            wr_rd;
    logic [DATA_WIDTH-1:0] wr_data;

    logic [DATA_WIDTH-1:0] pw_q;
    logic [3:0]            rw_q;
    logic                  le_q;
    logic                  pcl_q;
    logic [DATA_WIDTH-1:0] pcv_q;
    logic [CNT_WIDTH-1:0]  cnt_q [NUM_REGS];
    logic [CNT_WIDTH-1:0]  cnt_d [NUM_REGS];
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;

    rr_arbiter2 u_arb (
        .clk    (CLK),
        .rst_n  (RESET),
        .req    ({src.B_VALID, src.A_VALID}),
        .hold   (HOLD),
        .accept (xfer),
        .gnt    (gnt)
    );

    assign src.A_READY = gnt[0];
    assign src.B_READY = gnt[1];

    always_comb begin
        xfer    = |gnt;
        wr_rd   = gnt[1] ? src.B_RD   : src.A_RD;
        wr_data = gnt[1] ? src.B_DATA : src.A_DATA;
        is_pc   = (wr_rd == PC_INDEX);
    end

    // Reserve and commit hitting the same register cancel, so neither flag can fire there.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (RSV_VALID && (RSV_RD == 4'(i)) && !(xfer && (wr_rd == 4'(i)))) begin
                if (&cnt_q[i]) begin
                    ovf_d = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
                end
            end else if (xfer && (wr_rd == 4'(i)) && !(RSV_VALID && (RSV_RD == 4'(i)))) begin
                if (cnt_q[i] == '0) begin
                    unf_d = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] - CNT_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pw_q  <= '0;
            rw_q  <= '0;
            le_q  <= 1'b0;
            pcl_q <= 1'b0;
            pcv_q <= '0;
            cnt_q <= '{default: '0};
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            le_q  <= xfer && !is_pc;
            pcl_q <= xfer && is_pc;
            if (xfer && !is_pc) begin
                rw_q <= wr_rd;
                pw_q <= wr_data;
            end
            if (xfer && is_pc) begin
                pcv_q <= wr_data;
            end
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    always_comb begin
        BUSY = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            BUSY[i] = |cnt_q[i];
        end
    end

    assign PW       = pw_q;
    assign RW       = rw_q;
    assign LE       = le_q;
    assign PC_LOAD  = pcl_q;
    assign PC_VALUE = pcv_q;
    assign SB_OVF   = ovf_q;
    assign SB_UNF   = unf_q;

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Bench for regfile_write_ctrl: directed scenarios then random traffic against a reference model.
module tb_regfile_write_ctrl;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        HOLD;
    logic        RSV_VALID;
    logic [3:0]  RSV_RD;
    logic [31:0] PW;
    logic [3:0]  RW;
    logic        LE;
    logic        PC_LOAD;
    logic [31:0] PC_VALUE;
    logic [15:0] BUSY;
    logic        SB_OVF;
    logic        SB_UNF;

    regfile_write_ctrl_if #(.DATA_WIDTH(32)) bus ();

    regfile_write_ctrl #(
        .DATA_WIDTH (32),
        .NUM_REGS   (16),
        .PC_INDEX   (4'd15),
        .CNT_WIDTH  (2)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .HOLD      (HOLD),
        .src       (bus),
        .RSV_VALID (RSV_VALID),
        .RSV_RD    (RSV_RD),
        .PW        (PW),
        .RW        (RW),
        .LE        (LE),
        .PC_LOAD   (PC_LOAD),
        .PC_VALUE  (PC_VALUE),
        .BUSY      (BUSY),
        .SB_OVF    (SB_OVF),
        .SB_UNF    (SB_UNF)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: who won last, plain integer reservation counts, expected outputs.
    int          m_last;
    int          m_cnt [16];
    bit          m_ovf, m_unf, m_le, m_pcl;
    logic [3:0]  m_rw;
    logic [31:0] m_pw, m_pcv;
    bit          xa, xb;

    task automatic model_reset();
        m_last = 1;
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_ovf = 0; m_unf = 0; m_le = 0; m_pcl = 0;
        m_rw = '0; m_pw = '0; m_pcv = '0;
    endtask

    task automatic check_outputs();
        logic [15:0] eb;
        for (int i = 0; i < 16; i++) eb[i] = (m_cnt[i] != 0);
        chk("le", LE, m_le);
        chk("pc_load", PC_LOAD, m_pcl);
        chk("rw", RW, m_rw);
        chk("pw", PW, m_pw);
        chk("pc_value", PC_VALUE, m_pcv);
        chk("busy", BUSY, eb);
        chk("sb_ovf", SB_OVF, m_ovf);
        chk("sb_unf", SB_UNF, m_unf);
    endtask

    // Entered 1 time unit after a rising edge; returns 1 time unit after the next one.
    task automatic cyc();
        bit          ga, gb;
        logic [3:0]  rd;
        logic [31:0] d;
        int          rsv, com;
        #2;
        ga = !HOLD && bus.A_VALID && (!bus.B_VALID || m_last == 1);
        gb = !HOLD && bus.B_VALID && (!bus.A_VALID || m_last == 0);
        chk("a_ready", bus.A_READY, ga);
        chk("b_ready", bus.B_READY, gb);
        xa = ga; xb = gb;
        m_le = 0; m_pcl = 0;
        rsv = RSV_VALID ? int'(RSV_RD) : -1;
        com = -1;
        if (ga || gb) begin
            rd = gb ? bus.B_RD : bus.A_RD;
            d  = gb ? bus.B_DATA : bus.A_DATA;
            com = int'(rd);
            if (rd == 4'd15) begin
                m_pcl = 1; m_pcv = d;
            end else begin
                m_le = 1; m_rw = rd; m_pw = d;
            end
            m_last = gb ? 1 : 0;
        end
        if (!(rsv >= 0 && rsv == com)) begin
            if (rsv >= 0) begin
                if (m_cnt[rsv] == 3) m_ovf = 1; else m_cnt[rsv]++;
            end
            if (com >= 0) begin
                if (m_cnt[com] == 0) m_unf = 1; else m_cnt[com]--;
            end
        end
        @(posedge CLK);
        #1;
        check_outputs();
    endtask

    task automatic step(input bit h,
                        input bit av, input logic [3:0] ard, input logic [31:0] ad,
                        input bit bv, input logic [3:0] brd, input logic [31:0] bd,
                        input bit rv, input logic [3:0] rrd);
        HOLD = h;
        bus.A_VALID = av; bus.A_RD = ard; bus.A_DATA = ad;
        bus.B_VALID = bv; bus.B_RD = brd; bus.B_DATA = bd;
        RSV_VALID = rv; RSV_RD = rrd;
        cyc();
    endtask

    task automatic async_reset_pulse();
        RESET = 1'b0;
        #1;
        model_reset();
        chk("rst_a_ready", bus.A_READY, 1'b0);
        chk("rst_b_ready", bus.B_READY, 1'b0);
        check_outputs();
        #1;
        RESET = 1'b1;
    endtask

    initial begin
        bit          pa, pb;
        logic [3:0]  ard, brd;
        logic [31:0] ad, bd;

        RESET = 1'b0; HOLD = 1'b0; RSV_VALID = 1'b0; RSV_RD = '0;
        bus.A_VALID = 1'b1; bus.A_RD = 4'd3; bus.A_DATA = 32'h1;
        bus.B_VALID = 1'b1; bus.B_RD = 4'd4; bus.B_DATA = 32'h2;
        model_reset();
        #3;
        chk("inrst_a_ready", bus.A_READY, 1'b0);
        chk("inrst_b_ready", bus.B_READY, 1'b0);
        check_outputs();
        @(posedge CLK); #1;
        RESET = 1'b1;

        // First write after reset
        step(0, 1, 4'd3, 32'hDEADBEEF, 0, 4'd0, 32'h0, 0, 4'd0);
        chk("tp1_rw", RW, 4'd3);
        chk("tp1_pw", PW, 32'hDEADBEEF);
        step(0, 0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 0, 4'd0);
        chk("tp1_le_off", LE, 1'b0);

        // Contention: both sources keep requesting with fresh data after each transfer
        ard = 4'd1; ad = 32'hA000_0000; brd = 4'd2; bd = 32'hB000_0000;
        for (int k = 0; k < 4; k++) begin
            step(0, 1, ard, ad, 1, brd, bd, 0, 4'd0);
            chk("tp2_one_grant", 64'(xa) + 64'(xb), 64'd1);
            if (xa) begin ard = ard + 4'd2; ad = ad + 32'h11; end
            if (xb) begin brd = brd + 4'd2; bd = bd + 32'h22; end
        end

        // PC redirect
        step(0, 0, 4'd0, 32'h0, 1, 4'd15, 32'h0000_0100, 0, 4'd0);
        chk("tp3_pc_value", PC_VALUE, 32'h100);
        step(0, 0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 0, 4'd0);

        // Scoreboard counting on R5 and R7
        step(0, 0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 1, 4'd5);
        step(0, 0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 1, 4'd5);
        chk("tp4_busy5", BUSY[5], 1'b1);
        step(0, 1, 4'd5, 32'h55, 0, 4'd0, 32'h0, 0, 4'd0);
        chk("tp4_busy5_one", BUSY[5], 1'b1);
        step(0, 1, 4'd5, 32'h56, 0, 4'd0, 32'h0, 0, 4'd0);
        chk("tp4_busy5_clr", BUSY[5], 1'b0);
        step(0, 0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 1, 4'd7);
        step(0, 1, 4'd7, 32'h77, 0, 4'd0, 32'h0, 1, 4'd7);
        chk("tp4_busy7_held", BUSY[7], 1'b1);
        step(0, 1, 4'd7, 32'h78, 0, 4'd0, 32'h0, 0, 4'd0);

        // Saturation and underflow
        for (int k = 0; k < 4; k++) step(0, 0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 1, 4'd2);
        chk("tp5_ovf", SB_OVF, 1'b1);
        step(0, 1, 4'd9, 32'h99, 0, 4'd0, 32'h0, 0, 4'd0);
        chk("tp5_unf", SB_UNF, 1'b1);
        chk("tp5_rw9", RW, 4'd9);

        // HOLD blocks grants but not reservations, then reset mid-stream
        step(1, 1, 4'd6, 32'h66, 1, 4'd8, 32'h88, 1, 4'd5);
        step(0, 1, 4'd6, 32'h66, 0, 4'd0, 32'h0, 0, 4'd0);
        chk("tp6_busy", BUSY, 16'h0024);
        async_reset_pulse();
        step(0, 1, 4'd4, 32'h44, 1, 4'd8, 32'h88, 0, 4'd0);
        chk("tp6_a_first", RW, 4'd4);

        // Random traffic obeying the handshake rules
        pa = 0; pb = 0;
        for (int i = 0; i < 400; i++) begin
            if (!pa && $urandom_range(0, 2) != 0) begin
                pa = 1; ard = 4'($urandom_range(0, 15)); ad = $urandom;
            end
            if (!pb && $urandom_range(0, 2) != 0) begin
                pb = 1; brd = 4'($urandom_range(0, 15)); bd = $urandom;
            end
            step($urandom_range(0, 5) == 0, pa, ard, ad, pb, brd, bd,
                 $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)));
            if (xa) pa = 0;
            if (xb) pb = 0;
            if (i == 200) begin
                async_reset_pulse();
                pa = 0; pb = 0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
